iob_uart_host_bridge: RTL and testbench
=======================================

# iob_uart_host_bridge

Simulation-side IOb native master that drives the register interface of the testbench UART. It programs the UART at start-up, then moves bytes between two valid/ready byte streams from the host harness and the UART TX/RX registers by polling status. It sits directly upstream of the testbench UART's IOb port and replaces ad-hoc register pokes from the C++/Verilog harness.

## Interface
- `DATA_W`, 32: IOb data width.
- `ADDR_W`, 3: IOb byte-address width (UART register space).
- `DIV`, 16'd100: UART baud divisor written at init (clk cycles per bit).
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset, synchronous, active-low. One clock; all state sampled on rising `clk_i`.
- `iob_avalid_o`  out  1  request valid.
- `iob_addr_o`  out  ADDR_W  byte address.
- `iob_wdata_o`  out  DATA_W  write data, byte-lane aligned.
- `iob_wstrb_o`  out  DATA_W/8  byte strobes; 0 = read.
- `iob_rdata_i`  in  DATA_W  read data.
- `iob_ready_i`  in  1  request accepted.
- `iob_rvalid_i`  in  1  read data valid.
- `tx_data_i`  in  8  byte to transmit.
- `tx_valid_i`  in  1  TX byte offered.
- `tx_ready_o`  out  1  TX byte consumed this cycle.
- `rx_data_o`  out  8  received byte.
- `rx_valid_o`  out  1  RX byte held.
- `rx_ready_i`  in  1  harness takes RX byte.
- `init_done_o`  out  1  UART configured; streaming active.

## Operation
- UART accesses (addr / lane / meaning): write 0 lane0 SOFTRESET; write 2 lanes2-3 DIV; write 5 lane1 TXEN; write 6 lane2 RXEN; write 4 lane0 TXDATA; read 0 lane0 bit0 TXREADY; read 1 lane1 bit0 RXREADY; read 4 lane0 RXDATA. Address 4 → word offset 1, so lane0 of the second word; wdata placed at bit `8*(addr%4)`.
- FSM: INIT_RST (SOFTRESET=1) → INIT_CLR (SOFTRESET=0) → INIT_DIV (DIV) → INIT_TXEN (1) → INIT_RXEN (1) → IDLE.
- IDLE: choose next op. RX candidate when `rx_valid_o`=0; TX candidate when `tx_valid_i`=1. Both candidates → round-robin via 1-bit `last_rx` flag (reset 0, so RX first). Neither → stay IDLE.
- RX path: POLL_RX (read addr 1); bit8 of rdata=1 → RD_RX (read addr 4), capture `rdata[7:0]` into `rx_data_o`, set `rx_valid_o`, → IDLE; bit8=0 → IDLE.
- TX path: POLL_TX (read addr 0); bit0=1 → WR_TX (write addr 4, `tx_data_i` latched at POLL_TX entry); on write accept pulse `tx_ready_o` 1 cycle, → IDLE; bit0=0 → IDLE.
- RX output register: cleared when `rx_valid_o & rx_ready_i`; never overwritten while valid (RX polling suppressed).
- `tx_data_i` must stay stable while `tx_valid_i`=1 until `tx_ready_o`; bridge uses the latched copy.

## Timing
- Reset: all outputs 0, FSM INIT_RST, `last_rx`=0.
- Request: `iob_avalid_o` rises the cycle after entering an access state; addr/wdata/wstrb held constant while `iob_avalid_o`=1; dropped the cycle after `iob_avalid_o & iob_ready_i`.
- Writes complete at accept. Reads complete at `iob_rvalid_i` (same cycle as or later than accept); bridge never issues a new request before outstanding read's rvalid. Max one outstanding request.
- Zero-wait UART (ready same cycle, rvalid next): read op 3 cycles state-entry→IDLE, write 2 cycles.
- `init_done_o` rises the cycle IDLE is first entered; stays 1 until reset.
- `tx_ready_o` only asserted in cycle after WR_TX accept; never during init.
- `rx_valid_o` rises cycle after RXDATA rvalid.
- Reset mid-transaction: `iob_avalid_o` drops next edge; any in-flight rvalid after reset ignored; init sequence restarts.
- Simultaneous `rx_ready_i` take and new RXDATA capture cannot occur (capture gated by empty register).

## Test plan
- Reset release with zero-wait UART model → exactly five writes in order: (0,0x01,wstrb 0001), (0,0x00,0001), (2,DIV<<16,1100), (5,0x0100,0010), (6,0x010000,0100); `init_done_o`=1 after fifth.
- TX byte 0x41 with TXREADY=1 → read addr0, write addr4 wdata 0x41 wstrb 0001, `tx_ready_o` single pulse; loopback UART returns 0x41 on `rx_data_o`.
- TXREADY=0 for 10 polls then 1 → repeated reads of addr0, no TXDATA write until bit0=1; byte sent exactly once.
- RX bytes 0x55,0xAA with `rx_ready_i` held 0 for 50 cycles → `rx_valid_o`=1 with 0x55, no RXDATA reads while held; release → 0xAA delivered next, none lost.
- `iob_ready_i` stalled 7 cycles on a write → addr/wdata/wstrb stable all 7 cycles, single accepted transfer.
- `rst_n_i` low for 1 cycle mid-POLL_TX → `iob_avalid_o`, `init_done_o`, `rx_valid_o` 0 next cycle; init sequence reissued from SOFTRESET.

Source files
------------

// File: rtl/iob_uart_host_bridge.sv
// IOb native master that configures the testbench UART and then shuttles bytes
// between the host harness byte streams and the UART TX/RX registers by polling.
//
// Handshakes: a stream byte moves on a cycle where valid and ready are both 1.
// The producer holds valid and data steady until that cycle and may not take
// valid back early. The IOb request side follows the same rule for
// iob_avalid_o/iob_ready_i, and a read then completes on iob_rvalid_i.
module iob_uart_host_bridge #(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 3,
    parameter logic [15:0] DIV    = 16'd100
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [7:0]          tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [7:0]          rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                init_done_o
);

    localparam int STRB_W = DATA_W / 8;

    // UART register byte addresses
    localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(6);

    typedef enum logic [3:0] {
        INIT_RST,
        INIT_CLR,
        INIT_DIV,
        INIT_TXEN,
        INIT_RXEN,
        IDLE,
        POLL_RX,
        RD_RX,
        POLL_TX,
        WR_TX
    } state_t;

    state_t state;
    state_t state_next;

    logic              rd_pending;   // read accepted, rvalid not yet seen
    logic              last_rx;      // round-robin: last choice was RX
    logic [7:0]        tx_byte;      // copy of tx_data_i taken on POLL_TX entry

    logic              is_access;
    logic              is_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [15:0]       acc_val;
    logic [1:0]        acc_mask;
    logic [DATA_W-1:0] acc_wdata;
    logic [STRB_W-1:0] acc_wstrb;
    logic              acc_done;
    logic              tx_cand;
    logic              rx_cand;

    // Only bits 0, 8 and 7:0 of read data carry meaning.
    logic unused_rdata;
    assign unused_rdata = ^iob_rdata_i[DATA_W-1:9];

    // Place a value on the byte lanes selected by the low address bits.
    function automatic logic [DATA_W-1:0] lane_data(input logic [ADDR_W-1:0] a,
                                                    input logic [15:0] v);
        return DATA_W'(v) << (8 * (int'(a) % STRB_W));
    endfunction

    function automatic logic [STRB_W-1:0] lane_strb(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] m);
        return STRB_W'(m) << (int'(a) % STRB_W);
    endfunction

    // Decode the bus access belonging to the current state and detect its completion.
    always_comb begin
        is_access = 1'b1;
        is_write  = 1'b1;
        acc_addr  = '0;
        acc_val   = 16'h0000;
        acc_mask  = 2'b01;
        case (state)
            INIT_RST:  begin acc_addr = A_SOFTRESET; acc_val = 16'h0001; end
            INIT_CLR:  begin acc_addr = A_SOFTRESET; acc_val = 16'h0000; end
            INIT_DIV:  begin acc_addr = A_DIV; acc_val = DIV; acc_mask = 2'b11; end
            INIT_TXEN: begin acc_addr = A_TXEN; acc_val = 16'h0001; end
            INIT_RXEN: begin acc_addr = A_RXEN; acc_val = 16'h0001; end
            POLL_RX:   begin acc_addr = A_RXREADY; is_write = 1'b0; end
            RD_RX:     begin acc_addr = A_RXDATA; is_write = 1'b0; end
            POLL_TX:   begin acc_addr = A_TXREADY; is_write = 1'b0; end
            WR_TX:     begin acc_addr = A_TXDATA; acc_val = {8'h00, tx_byte}; end
            default:   begin is_access = 1'b0; is_write = 1'b0; end
        endcase
        acc_wdata = is_write ? lane_data(acc_addr, acc_val) : '0;
        acc_wstrb = is_write ? lane_strb(acc_addr, acc_mask) : '0;
        // Writes finish at accept; reads at rvalid, which may coincide with accept.
        if (is_write) begin
            acc_done = iob_avalid_o & iob_ready_i;
        end else begin
            acc_done = is_access & iob_rvalid_i & (rd_pending | (iob_avalid_o & iob_ready_i));
        end
    end

    // Next-state selection: init chain, then round-robin polling of RX and TX.
    always_comb begin
        state_next = state;
        // A byte being handed over this cycle is already consumed.
        tx_cand    = tx_valid_i & ~tx_ready_o;
        rx_cand    = ~rx_valid_o;
        case (state)
            INIT_RST:  if (acc_done) state_next = INIT_CLR;
            INIT_CLR:  if (acc_done) state_next = INIT_DIV;
            INIT_DIV:  if (acc_done) state_next = INIT_TXEN;
            INIT_TXEN: if (acc_done) state_next = INIT_RXEN;
            INIT_RXEN: if (acc_done) state_next = IDLE;
            IDLE: begin
                if (rx_cand && (!tx_cand || !last_rx)) state_next = POLL_RX;
                else if (tx_cand)                     state_next = POLL_TX;
            end
            POLL_RX:   if (acc_done) state_next = iob_rdata_i[8] ? RD_RX : IDLE;
            RD_RX:     if (acc_done) state_next = IDLE;
            POLL_TX:   if (acc_done) state_next = iob_rdata_i[0] ? WR_TX : IDLE;
            WR_TX:     if (acc_done) state_next = IDLE;
            default:   state_next = INIT_RST;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= INIT_RST;
        else          state <= state_next;
    end

    // Bus request register: issue one cycle after state entry, hold until accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            iob_avalid_o <= 1'b0;
            iob_addr_o   <= '0;
            iob_wdata_o  <= '0;
            iob_wstrb_o  <= '0;
            rd_pending   <= 1'b0;
        end else begin
            if (iob_avalid_o && iob_ready_i) begin
                iob_avalid_o <= 1'b0;
            end else if (is_access && !iob_avalid_o && !rd_pending) begin
                iob_avalid_o <= 1'b1;
                iob_addr_o   <= acc_addr;
                iob_wdata_o  <= acc_wdata;
                iob_wstrb_o  <= acc_wstrb;
            end
            if (acc_done)                                      rd_pending <= 1'b0;
            else if (iob_avalid_o && iob_ready_i && !is_write) rd_pending <= 1'b1;
        end
    end

    // Stream-side registers: TX latch/ack, RX holding register, arbitration and init flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_byte     <= 8'h00;
            tx_ready_o  <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            last_rx     <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            tx_ready_o <= (state == WR_TX) && acc_done;
            if (state == IDLE && state_next == POLL_TX) begin
                tx_byte <= tx_data_i;
                last_rx <= 1'b0;
            end else if (state == IDLE && state_next == POLL_RX) begin
                last_rx <= 1'b1;
            end
            if (state == INIT_RXEN && acc_done) init_done_o <= 1'b1;
            // Capture only happens with the register empty, so it never races a take.
            if (state == RD_RX && acc_done) begin
                rx_data_o  <= iob_rdata_i[7:0];
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_data_o  <= 8'h00;
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iob_uart_host_bridge.sv
// Bench for iob_uart_host_bridge: a zero-wait UART register model with optional
// loopback and write stalls, a table of init writes and a table of TX bytes,
// plus hand-written sequences for RX back-pressure, bus stalls and mid-op reset.
`timescale 1ns/1ps
module tb_iob_uart_host_bridge;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 3;
    localparam logic [15:0] DIV    = 16'd100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n_i      = 1'b0;
    logic              iob_avalid_o;
    logic [ADDR_W-1:0] iob_addr_o;
    logic [DATA_W-1:0] iob_wdata_o;
    logic [3:0]        iob_wstrb_o;
    logic [DATA_W-1:0] iob_rdata_i  = '0;
    logic              iob_ready_i  = 1'b0;
    logic              iob_rvalid_i = 1'b0;
    logic [7:0]        tx_data_i    = 8'h00;
    logic              tx_valid_i   = 1'b0;
    logic              tx_ready_o;
    logic [7:0]        rx_data_o;
    logic              rx_valid_o;
    logic              rx_ready_i   = 1'b1;
    logic              init_done_o;

    iob_uart_host_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV(DIV)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .iob_avalid_o (iob_avalid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_rdata_i  (iob_rdata_i),
        .iob_ready_i  (iob_ready_i),
        .iob_rvalid_i (iob_rvalid_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .init_done_o  (init_done_o)
    );

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xfer_t;

    typedef struct {
        logic [7:0]  tx_byte;
        int          busy_polls;
        logic [7:0]  exp_rx;
        logic [31:0] exp_wdata;
    } tx_vec_t;

    xfer_t      init_tbl[5];
    tx_vec_t    tx_tbl[4];
    xfer_t      log_q[$];     // every accepted IOb transfer, in order
    logic [7:0] uart_rx_q[$]; // UART receive FIFO
    logic [7:0] exp_q[$];     // bytes expected on rx_data_o, in order

    // ---------------- UART register model ----------------
    bit          loopback         = 1'b1;
    int          txrdy_zero_polls = 0;
    int          write_stall      = 0;
    int          stall_seen       = 0;
    logic [31:0] stall_wdata      = 32'h0;
    int          rd_cnt[8];
    int          txdata_writes    = 0;
    int          tx_ready_in_init = 0;
    bit          acc_pend         = 1'b0;
    xfer_t       acc;

    function automatic logic [31:0] uart_read(input logic [2:0] a);
        logic txr;
        logic rxr;
        txr = (txrdy_zero_polls == 0);
        rxr = (uart_rx_q.size() > 0);
        case (a)
            3'd0, 3'd1: begin
                if (a == 3'd0 && txrdy_zero_polls > 0) txrdy_zero_polls--;
                return {23'h0, rxr, 7'h0, txr};
            end
            3'd4: return rxr ? {24'h5A5A5A, uart_rx_q.pop_front()} : 32'h5A5A5A00;
            default: return 32'h0;
        endcase
    endfunction

    // Slave: finish the transfer accepted at the last edge, then decide the next accept.
    always @(negedge clk) begin
        iob_rvalid_i = 1'b0;
        if (acc_pend) begin
            acc_pend = 1'b0;
            log_q.push_back(acc);
            if (acc.wstrb == 4'b0000) begin
                rd_cnt[acc.addr]++;
                iob_rdata_i  = uart_read(acc.addr);
                iob_rvalid_i = 1'b1;
            end else if (acc.addr == 3'd4) begin
                txdata_writes++;
                if (loopback) uart_rx_q.push_back(acc.wdata[7:0]);
            end
        end
        iob_ready_i = 1'b0;
        if (iob_avalid_o && rst_n_i) begin
            if (iob_wstrb_o != 4'b0000 && write_stall > 0) begin
                write_stall--;
                stall_seen++;
                check("stall_addr", 32'(iob_addr_o), 32'd4);
                check("stall_wdata", iob_wdata_o, stall_wdata);
                check("stall_wstrb", 32'(iob_wstrb_o), 32'h1);
            end else begin
                iob_ready_i = 1'b1;
                acc_pend    = 1'b1;
                acc         = '{iob_addr_o, iob_wdata_o, iob_wstrb_o};
            end
        end
    end

    // Scoreboard: every RX hand-off must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n_i && tx_ready_o && !init_done_o) tx_ready_in_init++;
        if (rst_n_i && rx_valid_o && rx_ready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_extra_byte: got 0x%0h, expected no byte", rx_data_o);
            end else begin
                check("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        @(negedge clk);
        while (!init_done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("init_done", 32'(init_done_o), 32'h1);
    endtask

    task automatic wait_rx_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!rx_valid_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_rise", 32'(rx_valid_o), 32'h1);
    endtask

    task automatic wait_tx_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!tx_ready_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_seen", 32'(tx_ready_o), 32'h1);
        step();
        tx_valid_i = 1'b0;
        tx_data_i  = $urandom_range(0, 255);
        @(negedge clk);
        check("tx_ready_single_pulse", 32'(tx_ready_o), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int budget);
        step();
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        wait_tx_ready(budget);
    endtask

    task automatic wait_rx_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("rx_drain", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_init_log(input int base, input string tag);
        for (int i = 0; i < 5; i++) begin
            xfer_t got;
            got = (base + i < log_q.size()) ? log_q[base + i] : '{3'h7, 32'hFFFF_FFFF, 4'hF};
            check($sformatf("%s%0d_addr", tag, i), 32'(got.addr), 32'(init_tbl[i].addr));
            check($sformatf("%s%0d_wdata", tag, i), got.wdata, init_tbl[i].wdata);
            check($sformatf("%s%0d_wstrb", tag, i), 32'(got.wstrb), 32'(init_tbl[i].wstrb));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int    base;
        int    n;
        xfer_t wr;

        init_tbl[0] = '{3'd0, 32'h0000_0001, 4'b0001};
        init_tbl[1] = '{3'd0, 32'h0000_0000, 4'b0001};
        init_tbl[2] = '{3'd2, {DIV, 16'h0000}, 4'b1100};
        init_tbl[3] = '{3'd5, 32'h0000_0100, 4'b0010};
        init_tbl[4] = '{3'd6, 32'h0001_0000, 4'b0100};

        tx_tbl[0] = '{8'h41, 0,  8'h41, 32'h0000_0041};
        tx_tbl[1] = '{8'hC3, 10, 8'hC3, 32'h0000_00C3};
        tx_tbl[2] = '{8'h00, 0,  8'h00, 32'h0000_0000};
        tx_tbl[3] = '{8'hFF, 2,  8'hFF, 32'h0000_00FF};

        foreach (rd_cnt[a]) rd_cnt[a] = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_avalid", 32'(iob_avalid_o), 32'h0);
        check("rst_wstrb", 32'(iob_wstrb_o), 32'h0);
        check("rst_init_done", 32'(init_done_o), 32'h0);
        check("rst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("rst_tx_ready", 32'(tx_ready_o), 32'h0);

        // Init sequence: exactly five writes in order
        step();
        rst_n_i = 1'b1;
        wait_init(100);
        #1;
        check("init_write_count", 32'(log_q.size()), 32'd5);
        check_init_log(0, "init");

        // TX table with loopback
        for (int i = 0; i < 4; i++) begin
            step();
            loopback         = 1'b1;
            txrdy_zero_polls = tx_tbl[i].busy_polls;
            base             = log_q.size();
            txdata_writes    = 0;
            rd_cnt[0]        = 0;
            exp_q.push_back(tx_tbl[i].exp_rx);
            send_byte(tx_tbl[i].tx_byte, 500);
            wait_rx_drain(300);
            wr = '{3'h7, 32'hFFFF_FFFF, 4'hF};
            for (int k = base; k < log_q.size(); k++) if (log_q[k].wstrb != 4'b0) wr = log_q[k];
            check($sformatf("tx%0d_writes", i), 32'(txdata_writes), 32'd1);
            check($sformatf("tx%0d_polls", i), 32'(rd_cnt[0]), 32'(tx_tbl[i].busy_polls + 1));
            check($sformatf("tx%0d_addr", i), 32'(wr.addr), 32'd4);
            check($sformatf("tx%0d_wdata", i), wr.wdata, tx_tbl[i].exp_wdata);
            check($sformatf("tx%0d_wstrb", i), 32'(wr.wstrb), 32'h1);
        end

        // RX back-pressure: hold the first byte, no further polling while held
        step();
        loopback   = 1'b0;
        rx_ready_i = 1'b0;
        uart_rx_q.push_back(8'h55);
        uart_rx_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        wait_rx_valid(100);
        step();
        rd_cnt[1] = 0;
        rd_cnt[4] = 0;
        repeat (50) @(negedge clk);
        check("hold_rx_valid", 32'(rx_valid_o), 32'h1);
        check("hold_rx_data", 32'(rx_data_o), 32'h55);
        check("hold_rxdata_reads", 32'(rd_cnt[4]), 32'd0);
        check("hold_rxready_reads", 32'(rd_cnt[1]), 32'd0);
        step();
        rx_ready_i = 1'b1;
        wait_rx_drain(200);
        check("hold_fifo_empty", 32'(uart_rx_q.size()), 32'd0);

        // Write stalled for 7 cycles by the slave
        step();
        loopback      = 1'b1;
        write_stall   = 7;
        stall_seen    = 0;
        stall_wdata   = 32'h0000_003C;
        txdata_writes = 0;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 500);
        wait_rx_drain(200);
        check("stall_cycles", 32'(stall_seen), 32'd7);
        check("stall_writes", 32'(txdata_writes), 32'd1);

        // Reset for one cycle while a TXREADY poll is on the bus
        step();
        rx_ready_i = 1'b0;
        uart_rx_q.push_back(8'h99);
        wait_rx_valid(100);
        step();
        txrdy_zero_polls = 100000;
        tx_data_i        = 8'h77;
        tx_valid_i       = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(iob_avalid_o && iob_wstrb_o == 4'b0 && iob_addr_o == 3'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_poll_tx_seen", 32'(iob_avalid_o && iob_addr_o == 3'd0), 32'h1);
        step();
        rst_n_i = 1'b0;
        @(posedge clk);
        #2;
        rst_n_i = 1'b1;
        @(negedge clk);
        check("midrst_avalid", 32'(iob_avalid_o), 32'h0);
        check("midrst_init_done", 32'(init_done_o), 32'h0);
        check("midrst_rx_valid", 32'(rx_valid_o), 32'h0);
        step();
        base             = log_q.size();
        txrdy_zero_polls = 0;
        txdata_writes    = 0;
        rx_ready_i       = 1'b1;
        exp_q.push_back(8'h77);
        wait_init(100);
        #1;
        check_init_log(base, "reinit");
        wait_tx_ready(500);
        wait_rx_drain(200);
        check("reinit_tx_writes", 32'(txdata_writes), 32'd1);

        check("tx_ready_during_init", 32'(tx_ready_in_init), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
